// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared FSM state and direction/mode encodings for step_counter
package counter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/step_counter_next.sv
// rtl/step_counter_next.sv - combinational next-count and boundary-event logic
module step_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic             dir_i,
  input  logic             sat_i,
  input  logic             oneshot_i,
  output logic [WIDTH-1:0] next_o,
  output logic             event_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_E = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_E = (WIDTH + 1)'(MAX_VAL) + 1'b1;

  logic [WIDTH-1:0] vs;
  logic [WIDTH:0]   cnt_e;
  logic [WIDTH:0]   vs_e;
  logic [WIDTH:0]   sum_e;

  // Clamp the step, then form the exact result one bit wider than the count.
  always_comb begin
    vs      = (v_i > MAX_W) ? MAX_W : v_i;
    cnt_e   = {1'b0, count_i};
    vs_e    = {1'b0, vs};
    sum_e   = cnt_e + vs_e;
    next_o  = count_i;
    event_o = 1'b0;
    if (dir_i == DIR_UP) begin
      event_o = (vs_e != '0) && (sum_e >= MAX_E);
      if (sum_e <= MAX_E) begin
        next_o = WIDTH'(sum_e);
      end else if (sat_i == MODE_SAT) begin
        next_o = MAX_W;
      end else begin
        next_o = WIDTH'(sum_e - MOD_E);
      end
      if (event_o && oneshot_i) begin
        next_o = MAX_W;
      end
    end else begin
      event_o = (vs_e != '0) && (vs_e >= cnt_e);
      if (vs_e <= cnt_e) begin
        next_o = WIDTH'(cnt_e - vs_e);
      end else if (sat_i == MODE_SAT) begin
        next_o = '0;
      end else begin
        next_o = WIDTH'(cnt_e + MOD_E - vs_e);
      end
      if (event_o && oneshot_i) begin
        next_o = '0;
      end
    end
  end

endmodule

// File: rtl/step_counter.sv
// rtl/step_counter.sv - bounded up/down step counter with terminal-count pulse and sticky overflow
module step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] v,
  input  logic             dir,
  input  logic             sat,
  input  logic             oneshot,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_next;
  logic             step_event;
  logic [WIDTH-1:0] ld_val;

  step_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count_i   (count_q),
    .v_i       (v),
    .dir_i     (dir),
    .sat_i     (sat),
    .oneshot_i (oneshot),
    .next_o    (step_next),
    .event_o   (step_event)
  );

  assign ld_val = (d > MAX_W) ? MAX_W : d;

  // Next state: load beats step; tc defaults low so it only pulses on the event cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr_flag) begin
      ovf_d = 1'b0;
    end
    if (ld) begin
      count_d = ld_val;
      state_d = ST_RUN;
    end else if (en && (state_q == ST_RUN)) begin
      count_d = step_next;
      if (step_event) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (oneshot) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - directed table-driven bench for step_counter (WIDTH=8, MAX_VAL=9)
module tb_step_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic [7:0] d;
  logic [7:0] v;
  logic       dir;
  logic       sat;
  logic       oneshot;
  logic       clr_flag;
  logic [7:0] count;
  logic       tc;
  logic       ovf;
  logic       busy;

  int checks;
  int failures;

  step_counter #(
    .WIDTH   (8),
    .MAX_VAL (9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld       (ld),
    .d        (d),
    .v        (v),
    .dir      (dir),
    .sat      (sat),
    .oneshot  (oneshot),
    .clr_flag (clr_flag),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] d;
    logic       en;
    logic [7:0] v;
    logic       dir;
    logic       sat;
    logic       os;
    logic       clr;
    logic [7:0] c;
    logic       tc;
    logic       ovf;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic l, input int dv, input logic e, input int vv,
                     input logic dr, input logic s, input logic o, input logic cl,
                     input int ec, input logic et, input logic eo, input logic eb);
    vec_t x;
    x.rst = r; x.ld = l; x.d = 8'(dv); x.en = e; x.v = 8'(vv);
    x.dir = dr; x.sat = s; x.os = o; x.clr = cl;
    x.c = 8'(ec); x.tc = et; x.ovf = eo; x.busy = eb;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    @(negedge clk);
    rst = x.rst; ld = x.ld; d = x.d; en = x.en; v = x.v;
    dir = x.dir; sat = x.sat; oneshot = x.os; clr_flag = x.clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int steps;
    int tcs;
    checks = 0; failures = 0;
    rst = 1'b1; ld = 1'b0; d = '0; en = 1'b0; v = '0;
    dir = 1'b0; sat = 1'b0; oneshot = 1'b0; clr_flag = 1'b0;

    //   rst ld d   en v   dir sat os clr | count tc ovf busy
    add(1, 0, 0,  0, 0,  0, 0, 0, 0,   0, 0, 0, 1);  // reset state
    add(0, 1, 8,  0, 0,  0, 0, 0, 0,   8, 0, 0, 1);  // up wrap past max
    add(0, 0, 0,  1, 3,  0, 0, 0, 0,   1, 1, 1, 1);
    add(0, 0, 0,  0, 3,  0, 0, 0, 0,   1, 0, 1, 1);  // tc lasts one cycle
    add(0, 0, 0,  0, 0,  0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 2,  0, 0,  0, 0, 0, 0,   2, 0, 0, 1);  // down saturate
    add(0, 0, 0,  1, 5,  1, 1, 0, 0,   0, 1, 1, 1);
    add(0, 0, 0,  1, 5,  1, 1, 0, 0,   0, 1, 1, 1);
    add(0, 0, 0,  1, 0,  1, 1, 0, 0,   0, 0, 1, 1);  // vs=0 never an event
    add(0, 0, 0,  0, 0,  0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 1, 4,  0, 0,  0, 0, 0, 0,   4, 0, 0, 1);
    add(0, 0, 0,  1, 2,  0, 0, 0, 0,   6, 0, 0, 1);
    add(0, 0, 0,  1, 3,  1, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 0,  1, 3,  1, 0, 0, 0,   0, 1, 1, 1);  // lands on 0
    add(0, 0, 0,  1, 1,  1, 0, 0, 0,   9, 1, 1, 1);  // down wrap from 0
    add(0, 0, 0,  1, 0,  0, 0, 0, 0,   9, 0, 1, 1);  // vs=0 at max
    add(0, 0, 0,  1, 4,  0, 1, 0, 0,   9, 1, 1, 1);  // up saturate
    add(0, 0, 0,  0, 0,  0, 0, 0, 1,   9, 0, 0, 1);
    add(0, 1, 15, 0, 0,  0, 0, 0, 0,   9, 0, 0, 1);  // load clamped
    add(0, 1, 3,  0, 0,  0, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 0,  1, 20, 0, 0, 0, 0,   2, 1, 1, 1);  // step clamped to 9
    add(0, 1, 8,  0, 0,  0, 0, 0, 0,   8, 0, 1, 1);
    add(0, 0, 0,  1, 1,  0, 0, 0, 1,   9, 1, 1, 1);  // clr with event
    add(0, 0, 0,  0, 0,  0, 0, 0, 1,   9, 0, 0, 1);  // clr alone
    add(0, 1, 5,  1, 3,  0, 0, 0, 0,   5, 0, 0, 1);  // ld beats step
    add(0, 1, 7,  0, 0,  0, 0, 1, 0,   7, 0, 0, 1);  // oneshot
    add(0, 0, 0,  1, 2,  0, 0, 1, 0,   9, 1, 1, 0);
    add(0, 0, 0,  1, 2,  0, 0, 1, 0,   9, 0, 1, 0);
    add(0, 0, 0,  1, 2,  0, 0, 1, 0,   9, 0, 1, 0);
    add(0, 0, 0,  1, 3,  1, 0, 1, 0,   9, 0, 1, 0);
    add(0, 1, 4,  0, 0,  0, 0, 1, 0,   4, 0, 1, 1);
    add(0, 0, 0,  1, 6,  1, 0, 1, 0,   0, 1, 1, 0);  // oneshot ignores wrap
    add(1, 1, 5,  1, 3,  0, 0, 0, 1,   0, 0, 0, 1);  // reset in DONE
    add(0, 0, 0,  1, 3,  0, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 0,  1, 3,  0, 1, 0, 0,   6, 0, 0, 1);
    add(0, 0, 0,  1, 5,  0, 1, 0, 0,   9, 1, 1, 1);  // mode switch immediate

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      chk($sformatf("v%0d.count", i), int'(count), int'(vt[i].c));
      chk($sformatf("v%0d.tc", i), int'(tc), int'(vt[i].tc));
      chk($sformatf("v%0d.ovf", i), int'(ovf), int'(vt[i].ovf));
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vt[i].busy));
    end

    // Oneshot count-up from 0 by 1: DONE after exactly 9 steps, one tc.
    @(negedge clk);
    rst = 1'b0; ld = 1'b1; d = 8'd0; en = 1'b0; oneshot = 1'b1;
    dir = 1'b0; sat = 1'b0; clr_flag = 1'b0; v = 8'd1;
    @(posedge clk); #1;
    chk("seq.load_busy", int'(busy), 1);
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    steps = 0; tcs = 0;
    while (busy && steps < 20) begin
      @(posedge clk); #1;
      steps++;
      if (tc) tcs++;
    end
    chk("seq.steps", steps, 9);
    chk("seq.count", int'(count), 9);
    chk("seq.tcs", tcs, 1);

    // Reset mid-operation while enabled.
    @(negedge clk);
    ld = 1'b1; d = 8'd6; oneshot = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    ld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("seq.rst_count", int'(count), 0);
    chk("seq.rst_busy", int'(busy), 1);
    rst = 1'b0; en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/operand width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, inclusive upper count bound (1 <= MAX_VAL <= 2**WIDTH-1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port en  input  1  step enable.
REQ-006 SHALL have port ld  input  1  load count from d and restart.
REQ-007 SHALL have port d  input  WIDTH  load value.
REQ-008 SHALL have port v  input  WIDTH  step magnitude.
REQ-009 SHALL have port dir  input  1  0 = up, 1 = down.
REQ-010 SHALL have port sat  input  1  0 = wrap modulo MAX_VAL+1, 1 = saturate.
REQ-011 SHALL have port oneshot  input  1  1 = stop at first boundary event.
REQ-012 SHALL have port clr_flag  input  1  clear sticky ovf.
REQ-013 SHALL have port count  output  WIDTH  registered count, always in 0..MAX_VAL.
REQ-014 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have port ovf  output  1  sticky boundary-event flag.
REQ-016 SHALL have port busy  output  1  high when FSM in RUN.

Function
REQ-017 SHALL implement FSM states RUN and DONE; busy = (state == RUN).
REQ-018 SHALL apply priority rst > ld > step each cycle.
REQ-019 SHALL on ld load count <= min(d, MAX_VAL), state <= RUN, tc <= 0, in any state.
REQ-020 SHALL step only when en=1, ld=0, state=RUN; otherwise count holds and tc <= 0.
REQ-021 SHALL clamp effective step vs = min(v, MAX_VAL); sums computed at WIDTH+1 bits, no intermediate truncation.
REQ-022 SHALL up-step: count+vs <= MAX_VAL -> count+vs; else wrap -> count+vs-(MAX_VAL+1), sat -> MAX_VAL.
REQ-023 SHALL down-step: vs <= count -> count-vs; else wrap -> count+(MAX_VAL+1)-vs, sat -> 0.
REQ-024 SHALL define a boundary event as a step with vs > 0 whose exact result crosses or lands on MAX_VAL (up) or 0 (down); vs = 0 never raises an event.
REQ-025 SHALL on a boundary event set tc = 1 for exactly the cycle in which the new count is visible, and set ovf = 1.
REQ-026 SHALL with oneshot=1 on a boundary event load count with the boundary value (MAX_VAL up, 0 down) irrespective of sat, and enter DONE.
REQ-027 SHALL in DONE hold count, keep tc = 0, ignore en; leave DONE only via ld or rst.
REQ-028 SHALL on clr_flag clear ovf, unless a boundary event occurs in the same cycle, in which case ovf = 1.
REQ-029 SHALL sample dir, sat, oneshot every cycle; mode changes take effect on the next step, with no extra latency.

Reset
REQ-030 SHALL on rst set count = 0, tc = 0, ovf = 0, state = RUN (busy = 1) on the next rising edge, overriding ld, en and clr_flag, including mid-operation and in DONE.

Structure
REQ-031 SHALL place the state enum (RUN, DONE) and the direction/mode encodings in shared package counter_pkg.
REQ-032 SHALL compute the next count and the event flag in one combinational sub-module, step_counter_next; step_counter holds the FSM and registers only.

Verification (WIDTH=8, MAX_VAL=9)
REQ-033 SHALL test: ld d=8; then en, v=3, up, wrap -> count=1, tc pulse 1 cycle, ovf=1.
REQ-034 SHALL test: ld d=2; then en, v=5, down, sat -> count=0, tc=1; next en step again -> count=0, tc=1.
REQ-035 SHALL test: oneshot=1, ld d=7, en v=2 up -> count=9, tc=1, busy=0; 3 more en cycles -> count=9, tc=0; ld d=4 -> count=4, busy=1.
REQ-036 SHALL test: ld d=15 -> count=9; ld d=3 with v=20 up wrap -> count=2 (vs clamped to 9), ovf=1.
REQ-037 SHALL test: clr_flag with simultaneous event -> ovf stays 1; clr_flag alone next cycle -> ovf=0.
REQ-038 SHALL test: rst asserted with ld=1, d=5 while in DONE -> count=0, tc=0, ovf=0, busy=1.
